// File: rtl/hdmi_infoframe_pkg.sv
// Shared types, sizes and constant helpers for the run-time InfoFrame builder.
package hdmi_infoframe_pkg;

  localparam int unsigned INFOFRAME_MAX_PB = 28;
  localparam int unsigned PB_W             = 8;
  localparam int unsigned ADDR_W           = 5;
  localparam int unsigned PAYLOAD_W        = PB_W * (INFOFRAME_MAX_PB - 1);

  typedef logic [PB_W-1:0] infoframe_pb_t [0:INFOFRAME_MAX_PB-1];

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SUM       = 2'd1,
    WAIT_SWAP = 2'd2
  } infoframe_build_state_t;

  // PB0 such that header bytes plus PB0..PB(len) sum to zero mod 256.
  function automatic logic [PB_W-1:0] infoframe_checksum(
    input logic [6:0]           typ,
    input logic [7:0]           ver,
    input logic [4:0]           len,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [PB_W-1:0] acc;
    acc = 8'({1'b1, typ}) + ver + 8'({3'b000, len});
    for (int unsigned n = 1; n < INFOFRAME_MAX_PB; n++) begin
      if (n <= 32'(len)) acc = acc + payload[PB_W*n-1 -: PB_W];
    end
    return 8'(8'd0 - acc);
  endfunction

  // All-ones over PB1..PB(len), zero above: bytes past LENGTH never reach the wire.
  function automatic logic [PAYLOAD_W-1:0] infoframe_length_mask(input logic [4:0] len);
    logic [PAYLOAD_W-1:0] m;
    m = '0;
    for (int unsigned n = 1; n < INFOFRAME_MAX_PB; n++) begin
      if (n <= 32'(len)) m[PB_W*n-1 -: PB_W] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/infoframe_shadow_buffer.sv
// Host-writable PB1..PB27 shadow store with an indexed read port for the checksum pass.
module infoframe_shadow_buffer
  import hdmi_infoframe_pkg::*;
#(
  parameter logic [PAYLOAD_W-1:0] INIT_PAYLOAD = '0
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [PB_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PB_W-1:0]      rd_data_c,
  output logic [PAYLOAD_W-1:0] contents
);

  infoframe_pb_t mem;
  logic          wr_legal;
  logic          rd_legal;

  assign wr_legal = wr_en && (wr_addr != '0) && (wr_addr < ADDR_W'(INFOFRAME_MAX_PB));
  assign rd_legal = (rd_addr != '0) && (rd_addr < ADDR_W'(INFOFRAME_MAX_PB));

  // Slot 0 is never written; PB0 is produced by the checksum pass instead.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      for (int unsigned n = 1; n < INFOFRAME_MAX_PB; n++) begin
        mem[n] <= INIT_PAYLOAD[PB_W*n-1 -: PB_W];
      end
    end else if (wr_legal) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = rd_legal ? mem[rd_addr] : '0;

  always_comb begin
    contents = '0;
    for (int unsigned n = 1; n < INFOFRAME_MAX_PB; n++) begin
      contents[PB_W*n-1 -: PB_W] = mem[n];
    end
  end

endmodule

// File: rtl/infoframe_runtime_builder.sv
// Run-time programmable InfoFrame source: shadow writes, sequential checksum, atomic swap.
module infoframe_runtime_builder
  import hdmi_infoframe_pkg::*;
#(
  parameter logic [6:0]           TYPE         = 7'd3,
  parameter logic [7:0]           VERSION      = 8'd1,
  parameter logic [4:0]           LENGTH       = 5'd25,
  parameter logic [PAYLOAD_W-1:0] INIT_PAYLOAD = '0,
  parameter logic                 INIT_VALID   = 1'b0
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  input  logic              swap_ok,
  output logic              busy,
  output logic [23:0]       header,
  output logic [3:0][55:0]  sub,
  output logic              valid,
  output logic              update_done
);

  localparam logic [PB_W-1:0]      HDR_SUM     = 8'({1'b1, TYPE}) + VERSION + 8'({3'b000, LENGTH});
  localparam logic [PAYLOAD_W-1:0] PB_MASK     = infoframe_length_mask(LENGTH);
  localparam logic [PAYLOAD_W-1:0] INIT_ACTIVE = INIT_PAYLOAD & PB_MASK;
  localparam logic [PB_W-1:0]      INIT_PB0    = infoframe_checksum(TYPE, VERSION, LENGTH, INIT_PAYLOAD);

  infoframe_build_state_t state;
  infoframe_build_state_t state_next;

  logic                 load_acc;
  logic                 add_byte;
  logic                 do_swap;
  logic [PB_W-1:0]      acc;
  logic [ADDR_W-1:0]    idx;
  logic [PB_W-1:0]      rd_data_c;
  logic [PAYLOAD_W-1:0] shadow;
  logic [PAYLOAD_W-1:0] active_pb;
  logic [PB_W-1:0]      active_pb0;
  logic                 shadow_wr_c;

  assign shadow_wr_c = wr_en && (state == IDLE);

  infoframe_shadow_buffer #(
    .INIT_PAYLOAD (INIT_PAYLOAD)
  ) u_shadow (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .wr_en     (shadow_wr_c),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (idx),
    .rd_data_c (rd_data_c),
    .contents  (shadow)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_acc   = 1'b0;
    add_byte   = 1'b0;
    do_swap    = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          state_next = SUM;
          load_acc   = 1'b1;
        end
      end
      SUM: begin
        add_byte = 1'b1;
        if (idx == LENGTH) state_next = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (swap_ok) begin
          do_swap    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, active buffer and status flags; PB0 is the negated final sum.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      idx         <= '0;
      active_pb   <= INIT_ACTIVE;
      active_pb0  <= INIT_PB0;
      valid       <= INIT_VALID;
      busy        <= 1'b0;
      update_done <= 1'b0;
    end else begin
      busy        <= (state_next != IDLE);
      update_done <= do_swap;
      if (load_acc) begin
        acc <= HDR_SUM;
        idx <= ADDR_W'(1);
      end else if (add_byte) begin
        acc <= acc + rd_data_c;
        idx <= idx + ADDR_W'(1);
      end
      if (do_swap) begin
        active_pb  <= shadow & PB_MASK;
        active_pb0 <= 8'(8'd0 - acc);
        valid      <= 1'b1;
      end
    end
  end

  assign header = {3'b000, LENGTH, VERSION, 1'b1, TYPE};
  assign sub    = {active_pb, active_pb0};

endmodule

// File: tb/tb_infoframe_runtime_builder.sv
// Directed plus randomized bench for infoframe_runtime_builder against a byte-array reference model.
module tb_infoframe_runtime_builder;

  localparam logic [6:0] TYPE    = 7'd3;
  localparam logic [7:0] VERSION = 8'd1;
  localparam logic [4:0] LENGTH  = 5'd25;
  localparam int         LEN     = 25;

  logic             clk_pixel = 1'b0;
  logic             reset_n   = 1'b1;
  logic             wr_en     = 1'b0;
  logic [4:0]       wr_addr   = '0;
  logic [7:0]       wr_data   = '0;
  logic             commit    = 1'b0;
  logic             swap_ok   = 1'b0;
  logic             busy;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             valid;
  logic             update_done;

  int checks   = 0;
  int failures = 0;
  int sh  [1:27];
  int act [0:27];
  bit valid_m;

  infoframe_runtime_builder #(
    .TYPE         (TYPE),
    .VERSION      (VERSION),
    .LENGTH       (LENGTH),
    .INIT_PAYLOAD (216'd0),
    .INIT_VALID   (1'b0)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .swap_ok     (swap_ok),
    .busy        (busy),
    .header      (header),
    .sub         (sub),
    .valid       (valid),
    .update_done (update_done)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_checksum();
    int s = 128 + int'(TYPE) + int'(VERSION) + LEN;
    for (int n = 1; n <= LEN; n++) s += sh[n];
    return (256 - (s % 256)) % 256;
  endfunction

  function automatic logic [223:0] exp_sub();
    logic [223:0] v = '0;
    for (int n = 0; n < 28; n++) v[8*n +: 8] = 8'(act[n]);
    return v;
  endfunction

  task automatic publish();
    for (int n = 1; n < 28; n++) act[n] = (n <= LEN) ? sh[n] : 0;
    act[0]  = ref_checksum();
    valid_m = 1'b1;
  endtask

  task automatic model_reset();
    for (int n = 1; n < 28; n++) begin
      sh[n]  = 0;
      act[n] = 0;
    end
    act[0]  = ref_checksum();
    valid_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (a >= 5'd1 && a <= 5'd27) sh[int'(a)] = int'(d);
    tick();
    wr_en = 1'b0;
  endtask

  // Commit (optionally with a same-cycle write), hold swap_ok low for 'hold' WAIT_SWAP cycles,
  // and hammer the DUT with writes/commits that must be dropped while it is busy.
  task automatic run_commit(input bit wr, input logic [4:0] a, input logic [7:0] d,
                            input int hold, input string tag);
    int s       = LEN + 2 + hold;
    int done_k  = -1;
    int ud_cnt  = 0;
    bit busy_ok = 1'b1;
    bit sub_ok  = 1'b1;
    bit val_ok  = 1'b1;
    commit  = 1'b1;
    wr_en   = wr;
    wr_addr = a;
    wr_data = d;
    swap_ok = (hold == 0);
    if (wr && a >= 5'd1 && a <= 5'd27) sh[int'(a)] = int'(d);
    for (int k = 1; k <= s + 1; k++) begin
      tick();
      if (k == s) publish();
      if (update_done === 1'b1) begin
        ud_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (busy !== (k < s)) busy_ok = 1'b0;
      if (sub !== exp_sub()) sub_ok = 1'b0;
      if (valid !== valid_m) val_ok = 1'b0;
      if (k + 1 <= s) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = 8'($urandom);
        commit  = ($urandom_range(0, 3) == 0);
        if (hold == 0)         swap_ok = 1'b1;
        else if (k + 1 <= LEN + 1) swap_ok = 1'($urandom_range(0, 1));
        else                   swap_ok = (k + 1 == s);
      end else begin
        wr_en   = 1'b0;
        commit  = 1'b0;
        swap_ok = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, 256'(done_k), 256'(s));
    check({tag, "_done_pulses"}, 256'(ud_cnt), 256'(1));
    check({tag, "_busy_profile"}, 256'(busy_ok), 256'(1'b1));
    check({tag, "_sub_track"}, 256'(sub_ok), 256'(1'b1));
    check({tag, "_valid_track"}, 256'(val_ok), 256'(1'b1));
  endtask

  initial begin
    bit ud_seen;
    bit sub_hold;
    logic [223:0] snap;

    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_header", 256'(header), 256'(24'h190183));
    check("rst_pb0", 256'(sub[0][7:0]), 256'(8'h63));
    check("rst_sub", 256'(sub), 256'(exp_sub()));
    check("rst_valid", 256'(valid), 256'(1'b0));
    check("rst_busy", 256'(busy), 256'(1'b0));
    check("rst_update_done", 256'(update_done), 256'(1'b0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // PB1 = 0x55 with swap_ok held high
    write_byte(5'd1, 8'h55);
    run_commit(1'b0, 5'd0, 8'h00, 0, "pb1");
    check("pb1_pb0", 256'(sub[0][7:0]), 256'(8'h0E));
    check("pb1_byte", 256'(sub[0][15:8]), 256'(8'h55));
    check("pb1_valid", 256'(valid), 256'(1'b1));

    // Bytes beyond LENGTH are masked and excluded from the checksum
    write_byte(5'd1, 8'h00);
    write_byte(5'd27, 8'hFF);
    write_byte(5'd26, 8'hAA);
    run_commit(1'b0, 5'd0, 8'h00, 0, "beyond_len");
    check("beyond_pb0", 256'(sub[0][7:0]), 256'(8'h63));
    check("beyond_pb27", 256'(sub[3][55:48]), 256'(8'h00));
    check("beyond_pb26", 256'(sub[3][47:40]), 256'(8'h00));

    // Long wait for swap_ok with dropped writes/commits; illegal addresses ignored in IDLE
    write_byte(5'd0, 8'h3C);
    write_byte(5'd31, 8'hC3);
    write_byte(5'd9, 8'($urandom));
    run_commit(1'b0, 5'd0, 8'h00, 100, "hold");

    // Same-cycle write and commit on an otherwise all-zero payload
    for (int n = 1; n < 28; n++) write_byte(5'(n), 8'h00);
    run_commit(1'b1, 5'd5, 8'h10, 0, "same_cycle");
    check("same_pb5", 256'(sub[0][47:40]), 256'(8'h10));
    check("same_pb0", 256'(sub[0][7:0]), 256'(8'h53));

    // Randomized payload updates
    for (int it = 0; it < 6; it++) begin
      int nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) write_byte(5'($urandom_range(0, 31)), 8'($urandom));
      run_commit(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
                 $urandom_range(0, 6), "rand");
    end

    // Reset partway through the checksum pass aborts the update
    write_byte(5'd3, 8'h77);
    commit = 1'b1;
    tick();
    commit  = 1'b0;
    swap_ok = 1'b1;
    repeat (10) tick();
    check("midsum_busy", 256'(busy), 256'(1'b1));
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midsum_rst_sub", 256'(sub), 256'(exp_sub()));
    check("midsum_rst_valid", 256'(valid), 256'(1'b0));
    check("midsum_rst_busy", 256'(busy), 256'(1'b0));
    check("midsum_rst_update_done", 256'(update_done), 256'(1'b0));
    tick();
    tick();
    reset_n  = 1'b1;
    ud_seen  = 1'b0;
    sub_hold = 1'b1;
    snap     = exp_sub();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (update_done !== 1'b0) ud_seen = 1'b1;
      if (sub !== snap) sub_hold = 1'b0;
    end
    swap_ok = 1'b0;
    check("midsum_no_update_done", 256'(ud_seen), 256'(1'b0));
    check("midsum_sub_held", 256'(sub_hold), 256'(1'b1));

    // Normal operation resumes after the aborted update
    write_byte(5'd25, 8'hE1);
    run_commit(1'b0, 5'd0, 8'h00, 2, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/infoframe_runtime_builder.md
Name: infoframe_runtime_builder

Overview:
- Generic, run-time-programmable HDMI InfoFrame packet source.
- Generalises the fixed-content SPD InfoFrame: TYPE, VERSION and LENGTH are parameters, and payload bytes are written at run time through a byte port into a shadow buffer.
- A commit triggers a sequential checksum pass, then an atomic swap into the active buffer at a host-indicated safe point.
- Feeds the packet picker with header/sub words in the standard 24-bit header + 4x56-bit subpacket format.

Parameters:
- TYPE, 7'd3, InfoFrame type code; header byte 0 = {1'b1, TYPE}.
- VERSION, 8'd1, header byte 1.
- LENGTH, 5'd25, payload byte count (PB1..PBLENGTH), legal range 1..27; header byte 2 = {3'b0, LENGTH}.
- INIT_PAYLOAD, 216'd0, reset contents of PB1..PB27; PB(n) = INIT_PAYLOAD[8n-1:8n-8].
- INIT_VALID, 1'b0, reset value of valid.

Ports:
- clk_pixel  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  payload byte write strobe.
- wr_addr  in  5  payload byte index; 1..27 legal.
- wr_data  in  8  payload byte value.
- commit  in  1  single-cycle request to checksum and publish the shadow buffer.
- swap_ok  in  1  high when the active buffer may change (packet not being serialised).
- busy  out  1  high in any state other than IDLE.
- header  out  24  {{3'b0,LENGTH}, VERSION, {1'b1,TYPE}}; constant.
- sub  out  4x56  sub[i] = {PB(6+7i),...,PB(7i)}, from the active buffer.
- valid  out  1  active buffer holds committed or initialised content.
- update_done  out  1  one-cycle pulse on the cycle after a swap.

Behaviour:
- Reset, asynchronous assert:
  - shadow and active PB1..27 = INIT_PAYLOAD.
  - active PB0 = checksum of INIT_PAYLOAD, computed at elaboration by a constant function.
  - valid = INIT_VALID; busy = 0; update_done = 0; state = IDLE; accumulator = 0.
- Checksum rule:
  - PB0 = (0 - (hdr0 + hdr1 + hdr2 + PB1..PBLENGTH)) mod 256, so all header and payload bytes sum to 0 mod 256.
  - 8-bit wrap-around accumulation.
- Bytes with index > LENGTH:
  - Always presented as 8'h00 on sub and excluded from the checksum, regardless of written contents.
  - PB26/PB27 are always 0 when LENGTH=25.
- Writes:
  - Accepted only in IDLE.
  - wr_addr 0 or >27 is ignored.
  - Writes while busy are dropped; no error flag.
  - wr_en and commit in the same IDLE cycle: the write is applied and is included in the committed data.
- FSM states: IDLE, SUM, WAIT_SWAP.
  - IDLE: commit=1 -> SUM; accumulator loaded with (hdr0+hdr1+hdr2) mod 256; index = 1.
  - SUM:
    - One byte added per cycle for exactly LENGTH cycles.
    - After the cycle that adds PBLENGTH -> WAIT_SWAP, with PB0 = -acc latched.
  - WAIT_SWAP:
    - Stay while swap_ok=0.
    - On a cycle with swap_ok=1: active <= shadow + PB0, valid <= 1, update_done pulses next cycle, state -> IDLE.
  - commit outside IDLE is ignored.
- Latency: with commit at cycle t and swap_ok held high, the new sub values and update_done are visible at cycle t+LENGTH+2.
- sub changes only on a swap edge; never partially updated.
- Reset mid-SUM or mid-WAIT_SWAP:
  - Aborts the update.
  - Active and shadow return to INIT_PAYLOAD; any pending commit is lost.

Decomposition:
- Package hdmi_infoframe_pkg:
  - INFOFRAME_MAX_PB = 28.
  - typedef infoframe_pb_t (logic [7:0] array [0:27]).
  - Constant function infoframe_checksum(type, version, length, payload) for reset PB0 and bench reference.
  - Enum infoframe_build_state_t {IDLE, SUM, WAIT_SWAP}.
- One sub-module: infoframe_shadow_buffer.
  - 27x8 write port plus an indexed read port for the SUM sequencer.
  - Parallel output to the swap logic.
- FSM, accumulator and active registers live in the top module.

Test Plan:
- Reset with INIT_PAYLOAD=0, INIT_VALID=0, TYPE=3, VERSION=1, LENGTH=25 -> header=24'h190183, sub[0][7:0]=8'h63, valid=0, busy=0.
- Write PB1=8'h55, commit, swap_ok=1 -> busy high for 26 cycles, update_done at t+27, PB0=8'h0E, sub[0][15:8]=8'h55, valid=1.
- Write PB27=8'hFF with LENGTH=25, commit -> sub[3][55:48]=0 and PB0 unchanged from the all-zero payload value 8'h63.
- Commit with swap_ok=0 for 100 cycles, then pulse swap_ok -> sub holds old value throughout; it updates one cycle after the swap_ok cycle; writes and a second commit during the wait are dropped.
- wr_en(addr=5, data=8'h10) and commit in the same cycle -> published PB5=8'h10, PB0=8'h53.
- Assert reset_n low during SUM (cycle 10 of 25) -> outputs immediately return to reset values; no update_done pulse.
